// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence
// detectors that watch its line: FSM state encodings and the idle line level.
package seq_pattern_tx_pkg;

    // Fixed encodings so the detectors and the transmitter agree on state values.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Level the serial line rests at whenever no pattern bit is being driven.
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/seq_pattern_tx_piso.sv
// Parallel-in serial-out shift register. Load wins over shift; the serial
// output is always the MSB, and bits move towards the MSB on each shift.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    // Load a new word or shift left by one, zero-filling from the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign sout = q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter. A start pulse in IDLE captures a pattern,
// a frame length and a repeat count; the pattern is then sent MSB-first on A,
// one bit per clock, with a single idle-high gap between repeated frames and a
// one-cycle done pulse after the last frame. All outputs are Moore outputs.
//
// Handshake: start is a request that is only looked at while the FSM is in
// IDLE; a high start at an IDLE edge is accepted, at any other edge it is
// dropped. valid marks every cycle A carries a pattern bit; busy covers the
// whole burst (bits and gaps); done is a single-cycle completion pulse.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH),
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len_m1,
    input  logic [CNT_W-1:0] repeats,
    output logic             A,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH - 1);

    // Lengths beyond the register width are treated as a full-width frame.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (int'(l) > WIDTH - 1) begin
            clamp_len = LEN_MAX;
        end else begin
            clamp_len = l;
        end
    endfunction

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] pat_q;      // captured pattern, already left-aligned
    logic [LEN_W-1:0] len_q;      // captured (clamped) length minus one
    logic [LEN_W-1:0] bit_cnt;    // bits already sent in the current frame
    logic [CNT_W-1:0] rep_cnt;    // frames still to send after the current one

    logic [LEN_W-1:0] len_in;
    logic [WIDTH-1:0] pat_aligned;
    logic             start_acc;
    logic             frame_end;
    logic             last_frame;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             sh_msb;

    assign len_in      = clamp_len(len_m1);
    // First bit to send (bit len_m1) lands in the MSB of the shift register.
    assign pat_aligned = pattern << (LEN_MAX - len_in);
    assign start_acc   = (state == IDLE) && start;
    assign frame_end   = (state == SHIFT) && (bit_cnt == len_q);
    assign last_frame  = (rep_cnt == '0);

    // The shift register is loaded on capture and reloaded for each repeat;
    // the reload happens on the edge into GAP so the next frame is ready.
    assign sh_load  = start_acc || (frame_end && !last_frame);
    assign sh_shift = (state == SHIFT);
    assign sh_din   = start_acc ? pat_aligned : pat_q;

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .sout  (sh_msb)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (frame_end) state_nx = last_frame ? DONE : GAP;
            GAP:     state_nx = SHIFT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture registers and frame/repeat counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= '0;
            len_q   <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
        end else if (start_acc) begin
            pat_q   <= pat_aligned;
            len_q   <= len_in;
            rep_cnt <= repeats;
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            if (frame_end) begin
                bit_cnt <= '0;
                if (!last_frame) begin
                    rep_cnt <= rep_cnt - 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Output decode from state and the shift register MSB only.
    always_comb begin
        A     = IDLE_LEVEL;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            SHIFT: begin
                A     = sh_msb;
                valid = 1'b1;
                busy  = 1'b1;
            end
            GAP:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule
